me_sad_column_engine: RTL and testbench
=======================================

// Module: me_sad_column_engine
// PURPOSE
// Motion-estimation SAD datapath for one 8x8 current block against 16 vertically offset candidates.
// Each cycle one 23-pixel reference column is captured and split into 8 row windows of 16 pixels.
// An 8-column history is kept, and per-row partial SADs (PSAD) are computed for every candidate.
// The block sums the 8 row PSADs into 16 candidate SADs, which feed the downstream 16-way minimum finder.
// PARAMETERS
// PIXELS_IN_BATCH  16  candidates per column (vertical offsets 0..15)
// EDGE_LEN          8  block edge; rows per window set, columns in history
// BIT_DEPTH         8  bits per pixel, unsigned
// PSAD_BIT_WIDTH   11  width of one row partial SAD (8*255=2040)
// SAD_BIT_WIDTH    14  width of one candidate SAD (64*255=16320)
// PORTS
// clk_i        in   1     clock, all state updates on rising edge
// rst_n_i      in   1     reset; asynchronous and active-low
// data_in      in   184   reference column, pixel p at [p*8+:8], p=0..22 (p=0 top)
// cur_blk_i    in   512   current block, pixel (row r, col c) at [(r*8+c)*8+:8]
// ref_col_o    out  1024  row windows of newest column; window k at [k*128+:128] = pixels k..k+15
// psad_o       out  1408  PSAD(row j, cand i) at [(j*16+i)*11+:11]
// sad_o        out  224   SAD(cand i) at [i*14+:14]
// sad_valid_o  out  1     sad_o/psad_o reflect 8 columns captured since reset
// BEHAVIOUR
// - Reset (async, rst_n_i=0): column history, PSAD registers, fill counter and sad_valid_o clear to 0.
//   All outputs read 0 while reset is low and until new data propagates.
// - Stage 1, every rising edge, no enable:
//   - hist[0..6] <= hist[1..7]; hist[7] <= data_in, so hist[0] is the oldest column.
//   - ref_col_o is driven from hist[7].
//   - Window k of column h holds pixels k..k+15. Element i of window k is candidate i, row k.
// - Stage 2, every rising edge:
//   - PSAD[j][i] <= sum over c=0..7 of |hist[c].pixel(i+j) - cur_blk_i(row j, col c)|.
//   - History column c is paired with current-block column c.
// - sad_o[i] = sum over j=0..7 of PSAD[j][i], combinational from the registers, zero-extended 11->14 bits.
// - Arithmetic: unsigned absolute difference of 8-bit values; all sums are exact.
//   PSAD max 2040 and SAD max 16320, so neither sum can overflow.
// - Latency: column presented before edge n lands in hist[7] at edge n.
//   Columns presented before edges n..n+7 give valid sad_o after edge n+8, i.e. 2 edges after the last column.
// - Fill counter counts stage-1 captures after reset and saturates at 8.
// - sad_valid_o is a register: set at the first edge where the counter already equals 8 (edge n+8).
//   It stays 1 until reset.
// - cur_blk_i is sampled only by stage 2 and must be stable during the cycle before the PSAD edge.
// - Reset asserted mid-stream flushes the history; 8 new columns are needed before sad_valid_o rises again.
// - No handshake; the engine streams continuously. Zero columns shift in like any other data.
// TESTING
// - Reset: rst_n_i=0 with random data_in -> ref_col_o, psad_o, sad_o all 0, sad_valid_o=0.
//   Release reset, 7 columns -> sad_valid_o still 0.
// - Window split: data_in pixel p = p (0x00..0x16), one column.
//   -> ref_col_o window k element i = k+i, e.g. window 7 element 15 = 0x16.
// - Max sum: 8 columns of all 0xFF, cur_blk_i=0.
//   -> 2 edges after last column, every PSAD=2040 and every sad_o[i]=16320 (0x3FC0); sad_valid_o=1.
// - Candidate ramp: 8 columns with pixel p = p, cur_blk_i(row r, col c) = r.
//   -> PSAD[j][i] = 8*i, sad_o[i] = 64*i; sad_o[0]=0, sad_o[15]=960.
// - Column pairing: ref columns c=0..7 all pixels = c*16, cur_blk_i(r,c) = c*16.
//   -> all sad_o = 0. Swap cur column 0 to 0xFF -> every sad_o[i] = 8*255 = 2040.
// - Mid-stream reset: pulse rst_n_i low for one cycle during streaming.
//   -> outputs and sad_valid_o go to 0 immediately.
//   -> sad_valid_o rises again exactly 9 edges after release when 8 columns are fed.

Source files
------------

// File: rtl/me_sad_column_engine_if.sv
// Bus bundle for the SAD column engine: reference column and current block in, windows/PSAD/SAD out.
// Ports: data_in (23 px column), cur_blk_i (8x8 block), ref_col_o (8 windows), psad_o (8x16 PSAD),
//        sad_o (16 SADs), sad_valid_o. master = producer/consumer side, slave = engine side.
interface me_sad_column_engine_if;
  logic [183:0]  data_in;
  logic [511:0]  cur_blk_i;
  logic [1023:0] ref_col_o;
  logic [1407:0] psad_o;
  logic [223:0]  sad_o;
  logic          sad_valid_o;

  modport master (
    output data_in, cur_blk_i,
    input  ref_col_o, psad_o, sad_o, sad_valid_o
  );

  modport slave (
    input  data_in, cur_blk_i,
    output ref_col_o, psad_o, sad_o, sad_valid_o
  );
endinterface

// File: rtl/me_sad_column_engine.sv
// Motion-estimation SAD engine: 8-column reference history vs 8x8 current block, 16 vertical candidates.
// Latency: column lands in history on its capture edge; PSAD registered one edge later; SAD combinational.
// Backpressure: none, streams one column per clock. Ports: clk_i, rst_n_i (async low), bus (slave modport).
module me_sad_column_engine (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  me_sad_column_engine_if.slave    bus
);

  localparam int NB      = 16;          // candidates per column
  localparam int EL      = 8;           // block edge
  localparam int BD      = 8;           // bits per pixel
  localparam int PW      = 11;          // row PSAD width
  localparam int SW      = 14;          // candidate SAD width
  localparam int COL_PIX = NB + EL - 1; // pixels per reference column

  logic [COL_PIX*BD-1:0] r_hist [EL];
  logic [PW-1:0]         r_psad [EL][NB];
  logic [3:0]            r_fill_cnt;
  logic                  r_sad_valid;

  logic [PW-1:0]         w_psad_nxt [EL][NB];
  logic [SW-1:0]         w_sad [NB];

  function automatic logic [BD-1:0] f_absdiff(input logic [BD-1:0] a, input logic [BD-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Stage 1: column history shift register, hist[0] oldest, hist[7] newest.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int h = 0; h < EL; h++) r_hist[h] <= '0;
    end else begin
      for (int h = 0; h < EL-1; h++) r_hist[h] <= r_hist[h+1];
      r_hist[EL-1] <= bus.data_in;
    end
  end

  // Fill counter saturates at 8; valid is set on the first edge that sees it full,
  // which is the edge where the PSAD registers first hold 8 real columns.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fill_cnt  <= '0;
      r_sad_valid <= 1'b0;
    end else begin
      if (r_fill_cnt != 4'(EL)) r_fill_cnt <= r_fill_cnt + 4'd1;
      if (r_fill_cnt == 4'(EL)) r_sad_valid <= 1'b1;
    end
  end

  // Stage 2: candidate i, row j compares reference pixel i+j of history column c
  // with current-block pixel (j, c).
  always_comb begin
    for (int j = 0; j < EL; j++) begin
      for (int i = 0; i < NB; i++) begin
        w_psad_nxt[j][i] = '0;
        for (int c = 0; c < EL; c++) begin
          w_psad_nxt[j][i] = w_psad_nxt[j][i] +
            PW'(f_absdiff(r_hist[c][(i+j)*BD +: BD], bus.cur_blk_i[(j*EL+c)*BD +: BD]));
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int j = 0; j < EL; j++)
        for (int i = 0; i < NB; i++) r_psad[j][i] <= '0;
    end else begin
      for (int j = 0; j < EL; j++)
        for (int i = 0; i < NB; i++) r_psad[j][i] <= w_psad_nxt[j][i];
    end
  end

  // Candidate SAD: sum of the 8 row PSADs.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      w_sad[i] = '0;
      for (int j = 0; j < EL; j++) w_sad[i] = w_sad[i] + SW'(r_psad[j][i]);
    end
  end

  // Output packing. Window k of the newest column is pixels k..k+15.
  always_comb begin
    bus.ref_col_o = '0;
    bus.psad_o    = '0;
    bus.sad_o     = '0;
    for (int k = 0; k < EL; k++)
      for (int i = 0; i < NB; i++)
        bus.ref_col_o[(k*NB+i)*BD +: BD] = r_hist[EL-1][(k+i)*BD +: BD];
    for (int j = 0; j < EL; j++)
      for (int i = 0; i < NB; i++)
        bus.psad_o[(j*NB+i)*PW +: PW] = r_psad[j][i];
    for (int i = 0; i < NB; i++)
      bus.sad_o[i*SW +: SW] = w_sad[i];
  end

  assign bus.sad_valid_o = r_sad_valid;

endmodule

// File: tb/tb_me_sad_column_engine.sv
module tb_me_sad_column_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  me_sad_column_engine_if u_if ();

  me_sad_column_engine dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (u_if.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sad_of(input int i);
    return {18'b0, u_if.sad_o[i*14 +: 14]};
  endfunction

  function automatic logic [31:0] psad_of(input int j, input int i);
    return {21'b0, u_if.psad_o[(j*16+i)*11 +: 11]};
  endfunction

  function automatic logic [31:0] win_of(input int k, input int i);
    return {24'b0, u_if.ref_col_o[(k*16+i)*8 +: 8]};
  endfunction

  // Advance one rising edge; inputs change and outputs are sampled 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic col_const(input logic [7:0] v);
    for (int p = 0; p < 23; p++) u_if.data_in[p*8 +: 8] = v;
  endtask

  task automatic col_ramp();
    for (int p = 0; p < 23; p++) u_if.data_in[p*8 +: 8] = 8'(p);
  endtask

  task automatic col_rand();
    for (int p = 0; p < 23; p++) u_if.data_in[p*8 +: 8] = 8'($urandom_range(0, 255));
  endtask

  // mode 0: all zero, 1: pixel(r,c)=r, 2: pixel(r,c)=c*16
  task automatic cur_set(input int mode);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        u_if.cur_blk_i[(r*8+c)*8 +: 8] = (mode == 1) ? 8'(r) : (mode == 2) ? 8'(c*16) : 8'd0;
  endtask

  initial begin
    u_if.data_in   = '0;
    u_if.cur_blk_i = '0;

    // Reset with random input activity
    rst_n = 1'b0;
    cur_set(0);
    for (int n = 0; n < 3; n++) begin col_rand(); tick(); end
    chk("rst_ref_col_any", 32'(|u_if.ref_col_o), 32'd0);
    chk("rst_psad_any",    32'(|u_if.psad_o),    32'd0);
    chk("rst_sad_any",     32'(|u_if.sad_o),     32'd0);
    chk("rst_valid",       32'(u_if.sad_valid_o), 32'd0);

    // Release, 7 columns: not yet valid
    rst_n = 1'b1;
    for (int n = 0; n < 7; n++) begin col_rand(); tick(); end
    chk("seven_cols_valid", 32'(u_if.sad_valid_o), 32'd0);

    // Window split: 8th column is a ramp 0x00..0x16
    col_ramp();
    tick();
    chk("eighth_col_valid", 32'(u_if.sad_valid_o), 32'd0);
    chk("win7_elem15", win_of(7, 15), 32'h16);
    chk("win0_elem0",  win_of(0, 0),  32'h00);
    chk("win3_elem9",  win_of(3, 9),  32'd12);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 16; i++)
        chk($sformatf("win%0d_elem%0d", k, i), win_of(k, i), 32'(k+i));

    // Max sum: 8 columns of 0xFF, block zero
    cur_set(0);
    col_const(8'hFF);
    for (int n = 0; n < 8; n++) tick();
    tick();
    chk("max_valid", 32'(u_if.sad_valid_o), 32'd1);
    for (int i = 0; i < 16; i++) chk($sformatf("max_sad%0d", i), sad_of(i), 32'h3FC0);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 16; i++) chk($sformatf("max_psad_%0d_%0d", j, i), psad_of(j, i), 32'd2040);

    // Candidate ramp: pixel p=p, block pixel(r,c)=r -> PSAD[j][i]=8i, SAD[i]=64i
    cur_set(1);
    col_ramp();
    for (int n = 0; n < 9; n++) tick();
    chk("ramp_sad0",  sad_of(0),  32'd0);
    chk("ramp_sad15", sad_of(15), 32'd960);
    chk("ramp_sad7",  sad_of(7),  32'd448);
    chk("ramp_psad_3_5", psad_of(3, 5), 32'd40);
    chk("ramp_psad_7_15", psad_of(7, 15), 32'd120);
    for (int i = 0; i < 16; i++) chk($sformatf("ramp_sad%0d", i), sad_of(i), 32'(64*i));

    // Column pairing: history column c = c*16 everywhere, block column c = c*16
    cur_set(2);
    for (int c = 0; c < 8; c++) begin col_const(8'(c*16)); tick(); end
    tick();
    for (int i = 0; i < 16; i++) chk($sformatf("pair_sad%0d", i), sad_of(i), 32'd0);
    for (int c = 0; c < 8; c++) begin col_const(8'(c*16)); tick(); end
    for (int r = 0; r < 8; r++) u_if.cur_blk_i[(r*8)*8 +: 8] = 8'hFF;
    tick();
    for (int i = 0; i < 16; i++) chk($sformatf("swap_sad%0d", i), sad_of(i), 32'd2040);
    chk("swap_psad_4_2", psad_of(4, 2), 32'd255);

    // Mid-stream reset
    cur_set(0);
    col_const(8'h10);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ref_col_any", 32'(|u_if.ref_col_o), 32'd0);
    chk("mid_rst_psad_any",    32'(|u_if.psad_o),    32'd0);
    chk("mid_rst_sad_any",     32'(|u_if.sad_o),     32'd0);
    chk("mid_rst_valid",       32'(u_if.sad_valid_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    chk("post_rst_8_edges_valid", 32'(u_if.sad_valid_o), 32'd0);
    tick();
    chk("post_rst_9_edges_valid", 32'(u_if.sad_valid_o), 32'd1);
    for (int i = 0; i < 16; i++) chk($sformatf("post_rst_sad%0d", i), sad_of(i), 32'd1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
